// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits CLK, requests to send, shifts 8N1+odd parity out on device clock edges.
// Latency: busy the cycle after send_en; done/error one cycle after the closing condition is seen.
// Backpressure: send_en is honoured only in IDLE; strobes while busy are dropped without touching the held byte.
//
// Ports:
//   CLOCK_50              sole clock
//   reset                 asynchronous active-high reset; releases both lines at once
//   send_data[7:0]        byte to transmit, captured on send_en in IDLE
//   send_en               one-cycle request strobe
//   ps2_clk_in/dat_in     raw, asynchronous PS/2 pin levels
//   ps2_clk_oe/dat_oe     1 = pull the line low (open-drain, top level tri-states on 0)
//   busy                  transfer in progress
//   done / error          one-cycle completion / failure pulses, mutually exclusive
//
// Build option: define PS2_TX_ACK_CHECK_EN to treat a high DAT at the 11th falling edge as a failed ACK.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_en,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] START_LAST = 32'(START_TIMEOUT - 1);
  localparam logic [31:0] XFER_LAST  = 32'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        dat_bit_q, dat_bit_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cnt_clr;

  // Pin synchronizers; clk_prev_q holds the previous synchronized CLK for edge detection.
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_fall;

  assign clk_fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      dat_bit_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      dat_bit_q  <= dat_bit_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    shreg_d    = shreg_q;
    dat_bit_d  = dat_bit_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    cnt_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_en) begin
          // Frame after the start bit: data LSB first, odd parity, stop.
          shreg_d    = {1'b1, ~^send_data, send_data};
          dat_bit_d  = 1'b0;
          edge_cnt_d = '0;
          state_d    = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = REQ;
        end
      end

      REQ: begin
        state_d = BITS;
      end

      BITS: begin
        if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          dat_bit_d  = shreg_q[0];
          shreg_d    = {1'b0, shreg_q[9:1]};
          // The start-wait window ends at the first edge; the transfer window begins there.
          if (edge_cnt_q == 4'd0) begin
            cnt_clr = 1'b1;
          end
          if (edge_cnt_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (((edge_cnt_q == 4'd0) && (cnt_q == START_LAST)) ||
                     ((edge_cnt_q != 4'd0) && (cnt_q == XFER_LAST))) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      ACK: begin
        if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (dat_s2_q) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
          end
`else
          state_d = RELEASE;
`endif
        end else if (cnt_q == XFER_LAST) begin
          // A device that stops clocking before the ACK edge must not hang the host.
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      RELEASE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == XFER_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // One shared timer, restarted on every state change and held at zero while idle.
    if ((state_d != state_q) || (state_q == IDLE) || cnt_clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Line drives decode straight from registered state so reset releases them without a clock.
  assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_dat_oe = (state_q == REQ) || ((state_q == BITS) && !dat_bit_q);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled-down PS/2 device model on open-drain lines.
// Timers are shortened so every transfer fits in a few hundred clocks.
// Expected frames, parities and latencies are hand-computed constants.

module tb_ps2_host_tx;

  localparam int INH   = 50;
  localparam int START = 400;
  localparam int XFER  = 2000;
  localparam int HALF  = 20;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] send_data;
  logic       send_en;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk_low;
  logic dev_dat_low;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START),
    .XFER_TIMEOUT  (XFER)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .send_data (send_data),
    .send_en   (send_en),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle monitor, sampled on the falling clock edge.
  int cyc       = 0;
  int inh_cnt   = 0;
  int req_cnt   = 0;
  int req_cyc   = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;
  int both_cnt  = 0;
  logic err_oe    = 1'b0;
  logic err_busy  = 1'b0;
  logic done_busy = 1'b0;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
    if (ps2_clk_oe && ps2_dat_oe) begin
      req_cnt++;
      req_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_busy = busy;
    end
    if (error) begin
      err_cnt++;
      err_cyc  = cyc;
      err_oe   = ps2_clk_oe | ps2_dat_oe;
      err_busy = busy;
    end
    if (done && error) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    send_data = b;
    send_en   = 1'b1;
    @(negedge CLOCK_50);
    send_en   = 1'b0;
  endtask

  task automatic wait_evt(input int d0, input int e0, input int budget);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < budget) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk("evt_in_time", 32'(t < budget), 32'd1);
    repeat (2) @(negedge CLOCK_50);
  endtask

  // Device side: waits for the request-to-send, then clocks 11 pulses.
  // Bits are read on rising CLK; ACK is pulled low before the 11th fall when ack=1.
  // abort_at>0 leaves CLK held low after that falling edge and returns early.
  task automatic dev_xfer(input logic ack, input int abort_at,
                          output logic [9:0] rx, output logic start_lvl);
    int t;
    rx        = '0;
    start_lvl = 1'b1;
    t = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && t < INH + 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk("start_request_seen", 32'(t < INH + 100), 32'd1);
    if (t >= INH + 100) return;
    repeat (HALF) @(negedge CLOCK_50);
    start_lvl = ps2_dat_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) begin
        dev_dat_low = 1'b1;
        @(negedge CLOCK_50);
      end
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        repeat (5) @(negedge CLOCK_50);
        return;
      end
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge CLOCK_50);
      if (i <= 10) rx[i-1] = ps2_dat_in;
      repeat (HALF - HALF / 2) @(negedge CLOCK_50);
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] rx;
    logic       st;
    int d0, e0, i0, r0;

    reset       = 1'b1;
    send_en     = 1'b0;
    send_data   = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_error",  32'(error),      32'd0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    // 0xED: LSB-first 1,0,1,1,0,1,1,1; six ones -> odd parity bit 1.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = req_cnt;
    send_byte(8'hED);
    chk("ed_busy_set", 32'(busy), 32'd1);
    dev_xfer(1'b1, 0, rx, st);
    wait_evt(d0, e0, 200);
    chk("ed_start_bit", 32'(st),       32'd0);
    chk("ed_data",      32'(rx[7:0]),  32'hED);
    chk("ed_parity",    32'(rx[8]),    32'd1);
    chk("ed_stop",      32'(rx[9]),    32'd1);
    chk("ed_inhibit",   32'(inh_cnt - i0), 32'(INH));
    chk("ed_req_cyc",   32'(req_cnt - r0), 32'd1);
    chk("ed_done",      32'(done_cnt - d0), 32'd1);
    chk("ed_no_err",    32'(err_cnt - e0),  32'd0);
    chk("ed_done_busy", 32'(done_busy), 32'd0);
    chk("ed_busy_end",  32'(busy),      32'd0);

    // 0xF4: five ones -> parity bit 0.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    dev_xfer(1'b1, 0, rx, st);
    wait_evt(d0, e0, 200);
    chk("f4_data",   32'(rx[7:0]), 32'hF4);
    chk("f4_parity", 32'(rx[8]),   32'd0);
    chk("f4_done",   32'(done_cnt - d0), 32'd1);

    // Silent device: error START+1 samples after the REQ cycle (START cycles after leaving REQ).
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h12);
    wait_evt(d0, e0, INH + START + 100);
    chk("to_err",     32'(err_cnt - e0),  32'd1);
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);
    chk("to_latency", 32'(err_cyc - req_cyc), 32'(START + 1));
    chk("to_oe",      32'(err_oe),   32'd0);
    chk("to_busy",    32'(err_busy), 32'd0);

    // Device leaves DAT high at the ACK edge.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    dev_xfer(1'b0, 0, rx, st);
    wait_evt(d0, e0, 200);
    chk("nack_data", 32'(rx[7:0]), 32'hA5);
`ifdef PS2_TX_ACK_CHECK_EN
    chk("nack_err",  32'(err_cnt - e0),  32'd1);
    chk("nack_done", 32'(done_cnt - d0), 32'd0);
`else
    chk("nack_done", 32'(done_cnt - d0), 32'd1);
    chk("nack_err",  32'(err_cnt - e0),  32'd0);
`endif

    // Reset after the 4th falling edge while the host is driving a 0 bit.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00);
    dev_xfer(1'b1, 4, rx, st);
    chk("ab_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
    reset = 1'b1;
    #1;
    chk("ab_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("ab_dat_oe", 32'(ps2_dat_oe), 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ab_no_err",  32'(err_cnt - e0),  32'd0);

    // Fresh transfer after the reset: 0xFF, eight ones -> parity 1.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF);
    dev_xfer(1'b1, 0, rx, st);
    wait_evt(d0, e0, 200);
    chk("ff_data",   32'(rx[7:0]), 32'hFF);
    chk("ff_parity", 32'(rx[8]),   32'd1);
    chk("ff_done",   32'(done_cnt - d0), 32'd1);

    // Second strobe during the inhibit phase must not disturb the byte in flight.
    d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
    send_byte(8'hED);
    repeat (10) @(negedge CLOCK_50);
    send_byte(8'h55);
    dev_xfer(1'b1, 0, rx, st);
    wait_evt(d0, e0, 200);
    repeat (100) @(negedge CLOCK_50);
    chk("bsy_data", 32'(rx[7:0]), 32'hED);
    chk("bsy_done", 32'(done_cnt - d0), 32'd1);
    chk("bsy_req",  32'(req_cnt - r0),  32'd1);
    chk("bsy_idle", 32'(busy), 32'd0);

    chk("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
